// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator core: opcodes, FSM state encoding
// and instruction-word layout.
package accumulator_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_NOT = 4'hB;
  localparam logic [3:0] OP_SHL = 4'hC;
  localparam logic [3:0] OP_SHR = 4'hD;
  localparam logic [3:0] OP_LDI = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Opcodes 1..7 reach data memory; everything else completes in EXEC.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= OP_LDA) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/accumulator_core_if.sv
// Data-memory req/ack bus between the core (master) and the data RAM (slave).
interface accumulator_core_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/acc_alu.sv
// Combinational ALU for the accumulator core. Anything that is not an
// arithmetic/logic opcode passes operand b through with the carry untouched.
module acc_alu
  import accumulator_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              carry_mod
);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    result    = b;
    carry_out = 1'b0;
    carry_mod = 1'b0;
    case (op)
      OP_ADD: begin
        {carry_out, result} = {1'b0, a} + {1'b0, b};
        carry_mod           = 1'b1;
      end
      OP_SUB: begin
        result    = a - b;
        carry_out = (a < b);
        carry_mod = 1'b1;
      end
      OP_AND: begin
        result    = a & b;
        carry_mod = 1'b1;
      end
      OP_OR: begin
        result    = a | b;
        carry_mod = 1'b1;
      end
      OP_XOR: begin
        result    = a ^ b;
        carry_mod = 1'b1;
      end
      OP_NOT: begin
        result    = ~a;
        carry_mod = 1'b1;
      end
      OP_SHL: begin
        result    = {a[DATA_W-2:0], 1'b0};
        carry_out = a[DATA_W-1];
        carry_mod = 1'b1;
      end
      OP_SHR: begin
        result    = {1'b0, a[DATA_W-1:1]};
        carry_out = a[0];
        carry_mod = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/accumulator_core.sv
// Multicycle single-operand processor: FETCH/EXEC/MEM/HALT FSM, PC, IR,
// accumulator, Z/C flags and a registered req/ack data-memory port.
module accumulator_core
  import accumulator_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [OPCODE_W+ADDR_W-1:0] imem_data,
  accumulator_core_if.master       dmem,
  output logic [DATA_W-1:0]        acc_out,
  output logic                     flag_z,
  output logic                     flag_c,
  output logic                     halted
);

  logic [1:0]                 r_state;
  logic [ADDR_W-1:0]          r_pc;
  logic [OPCODE_W+ADDR_W-1:0] r_ir;
  logic [DATA_W-1:0]          r_acc;
  logic                       r_z;
  logic                       r_c;
  logic                       r_req;
  logic                       r_we;
  logic [ADDR_W-1:0]          r_addr;
  logic [DATA_W-1:0]          r_wdata;

  logic [3:0]        w_op;
  logic [ADDR_W-1:0] w_field;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_result;
  logic              w_carry;
  logic              w_carry_mod;

  assign w_op    = r_ir[OPCODE_W+ADDR_W-1:ADDR_W];
  assign w_field = r_ir[ADDR_W-1:0];
  assign w_imm   = DATA_W'(w_field);
  // In MEM the ALU consumes the returned data word; in EXEC the immediate.
  assign w_alu_b = (r_state == ST_MEM) ? dmem.dmem_rdata : w_imm;

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op        (w_op),
    .a         (r_acc),
    .b         (w_alu_b),
    .result    (w_result),
    .carry_out (w_carry),
    .carry_mod (w_carry_mod)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_acc   <= '0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (run) begin
            r_ir    <= imem_data;
            r_pc    <= r_pc + 1'b1;
            r_state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          r_state <= ST_FETCH;
          case (w_op)
            OP_NOT, OP_SHL, OP_SHR, OP_LDI: begin
              r_acc <= w_result;
              r_z   <= (w_result == '0);
              if (w_carry_mod) r_c <= w_carry;
            end
            OP_JMP: r_pc <= w_field;
            OP_JZ:  if (r_z) r_pc <= w_field;
            OP_JC:  if (r_c) r_pc <= w_field;
            OP_HLT: r_state <= ST_HALT;
            default: begin
              if (is_mem_op(w_op)) begin
                r_req   <= 1'b1;
                r_we    <= (w_op == OP_STA);
                r_addr  <= w_field;
                r_wdata <= r_acc;
                r_state <= ST_MEM;
              end
            end
          endcase
        end

        ST_MEM: begin
          if (dmem.dmem_ack) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= ST_FETCH;
            if (w_op != OP_STA) begin
              r_acc <= w_result;
              r_z   <= (w_result == '0);
              if (w_carry_mod) r_c <= w_carry;
            end
          end
        end

        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign imem_addr       = r_pc;
  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;
  assign acc_out         = r_acc;
  assign flag_z          = r_z;
  assign flag_c          = r_c;
  assign halted          = (r_state == ST_HALT);

endmodule
